// File: rtl/handshake_constant_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_constant_arbiter
//
// One constant source shared by NUM_REQ control-token requesters in an elastic
// dataflow fabric. Each cycle the requesters asserting ctrl_valid are arbitrated
// round-robin. The winner's token goes into a one-deep output slot. The slot
// presents CONST_VALUE on outs, and the winner's index on outs_index, so that a
// downstream demux or branch can route the constant back to its consumer.
//
// Valid/ready semantics (both sides):
//   A token moves across an interface on a rising clock edge where valid and
//   ready are both high. A producer holding valid=1 keeps it (and its payload)
//   stable until it is accepted. Ready may depend combinationally on valid.
//   On this block, ctrl_ready depends combinationally on ctrl_valid and
//   outs_ready.
//
// Ports:
//   clk         in   1           clock, rising edge
//   rst         in   1           asynchronous reset, active-high
//   ctrl_valid  in   NUM_REQ     per-requester control token valid
//   ctrl_ready  out  NUM_REQ     per-requester accept (one-hot or zero)
//   outs        out  DATA_WIDTH  constant value, always CONST_VALUE
//   outs_index  out  IDX_WIDTH   requester index of the buffered token
//   outs_valid  out  1           output slot holds a token
//   outs_ready  in   1           downstream accept
//   dbg_ptr     out  IDX_WIDTH   round-robin pointer (debug visibility)
//
// Parameters:
//   DATA_WIDTH   width of outs
//   NUM_REQ      number of requesters, 2..16
//   IDX_WIDTH    width of outs_index, >= clog2(NUM_REQ)
//   CONST_VALUE  constant emitted on outs (zero-extended/truncated)
// -----------------------------------------------------------------------------
module handshake_constant_arbiter #(
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REQ     = 4,
  parameter int          IDX_WIDTH   = 2,
  parameter logic [63:0] CONST_VALUE = 64'h0000_0000_07D2_0607
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [IDX_WIDTH-1:0]  dbg_ptr
);

  // Output slot occupancy
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t            r_slot;
  logic [IDX_WIDTH-1:0]   r_outs_index;
  logic [IDX_WIDTH-1:0]   r_ptr;

  logic                   w_load;
  logic                   w_any;
  logic                   w_xfer;
  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_WIDTH-1:0]   w_grant_idx;
  logic [IDX_WIDTH-1:0]   w_ptr_next;
  int                     w_dist;
  int                     w_best_dist;

  // The constant never depends on state, not even during reset.
  assign outs = DATA_WIDTH'(CONST_VALUE);

  // The slot can take a new token when it is empty or when its current token
  // leaves this very cycle. This gives 1 token/cycle at full throughput.
  assign w_load = (r_slot == SLOT_EMPTY) || outs_ready;

  // Round-robin scan starting at r_ptr. Each requester's distance from the
  // pointer is computed with an explicit modulo wrap. The valid requester with
  // the smallest distance wins. This avoids a variable bit-select, and it
  // behaves correctly when NUM_REQ is not a power of two.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_any       = 1'b0;
    w_best_dist = NUM_REQ;
    w_dist      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(r_ptr);
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_REQ;
      end
      if (ctrl_valid[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_grant     = '0;
        w_grant[i]  = 1'b1;
        w_grant_idx = IDX_WIDTH'(i);
        w_any       = 1'b1;
      end
    end
  end

  // The pointer moves to the requester just after the winner, wrapping at
  // NUM_REQ-1 instead of at the IDX_WIDTH power-of-two boundary.
  assign w_ptr_next = (w_grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                               : w_grant_idx + 1'b1;

  assign w_xfer = w_load && w_any;

  // ctrl_ready is masked while rst is high, so no acceptance is reported in a
  // cycle whose edge the reset discards.
  assign ctrl_ready = (rst || !w_load) ? '0 : w_grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot       <= SLOT_EMPTY;
      r_outs_index <= '0;
      r_ptr        <= '0;
    end else begin
      case (r_slot)
        SLOT_EMPTY: begin
          if (w_xfer) begin
            r_slot       <= SLOT_FULL;
            r_outs_index <= w_grant_idx;
            r_ptr        <= w_ptr_next;
          end
        end
        SLOT_FULL: begin
          if (w_xfer) begin
            // Drain and refill on the same edge.
            r_outs_index <= w_grant_idx;
            r_ptr        <= w_ptr_next;
          end else if (outs_ready) begin
            // Drain only. The index is kept and the pointer does not move.
            r_slot <= SLOT_EMPTY;
          end
          // On a stall (!outs_ready), everything holds.
        end
        default: begin
          r_slot <= SLOT_EMPTY;
        end
      endcase
    end
  end

  assign outs_valid = (r_slot == SLOT_FULL);
  assign outs_index = r_outs_index;
  assign dbg_ptr    = r_ptr;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for handshake_constant_arbiter.
// It has two instances: the default 4-requester configuration, and a
// 3-requester configuration that exercises the non-power-of-two wrap.
// Inputs change 1ns after a rising edge. Outputs are sampled on the falling
// edge, or mid-cycle in the asynchronous reset scenario.
// -----------------------------------------------------------------------------
module tb_handshake_constant_arbiter;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 4-requester instance
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [31:0] outs;
  logic [1:0]  outs_index;
  logic        outs_valid;
  logic        outs_ready;
  logic [1:0]  dbg_ptr;

  // 3-requester instance
  logic [2:0]  ctrl_valid3;
  logic [2:0]  ctrl_ready3;
  logic [31:0] outs3;
  logic [1:0]  outs_index3;
  logic        outs_valid3;
  logic        outs_ready3;
  logic [1:0]  dbg_ptr3;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] EXP_CONST = 32'h07D2_0607;

  handshake_constant_arbiter #(
    .DATA_WIDTH(32), .NUM_REQ(4), .IDX_WIDTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .outs(outs), .outs_index(outs_index), .outs_valid(outs_valid),
    .outs_ready(outs_ready), .dbg_ptr(dbg_ptr)
  );

  handshake_constant_arbiter #(
    .DATA_WIDTH(32), .NUM_REQ(3), .IDX_WIDTH(2)
  ) dut3 (
    .clk(clk), .rst(rst),
    .ctrl_valid(ctrl_valid3), .ctrl_ready(ctrl_ready3),
    .outs(outs3), .outs_index(outs_index3), .outs_valid(outs_valid3),
    .outs_ready(outs_ready3), .dbg_ptr(dbg_ptr3)
  );

  // ---------------------------------------------------------------- driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    rst = 1'b1; ctrl_valid = 4'b1111; outs_ready = 1'b0;
    ctrl_valid3 = 3'b000; outs_ready3 = 1'b0;
    #3;
    n_tests++; if (ctrl_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ctrl_ready got=%b exp=0000", ctrl_ready); end
    n_tests++; if (outs_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outs_valid got=%b exp=0", outs_valid); end
    n_tests++; if (outs !== EXP_CONST) begin n_fail++; $display("FAIL reset_outs got=%h exp=%h", outs, EXP_CONST); end
    n_tests++; if (outs_index !== 2'd0) begin n_fail++; $display("FAIL reset_outs_index got=%0d exp=0", outs_index); end
    tick();
    rst = 1'b0; ctrl_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++; if (outs_valid !== 1'b0) begin n_fail++; $display("FAIL idle_outs_valid cyc=%0d got=%b exp=0", c, outs_valid); end
      n_tests++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL idle_ptr cyc=%0d got=%0d exp=0", c, dbg_ptr); end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    logic [1:0] exp_idx;
    ctrl_valid = 4'b1111; outs_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_rdy = 4'b0001 << (c % 4);
      n_tests++; if (ctrl_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant cyc=%0d got=%b exp=%b", c, ctrl_ready, exp_rdy); end
      if (c > 0) begin
        exp_idx = 2'((c - 1) % 4);
        n_tests++; if (outs_valid !== 1'b1) begin n_fail++; $display("FAIL rr_outs_valid cyc=%0d got=%b exp=1", c, outs_valid); end
        n_tests++; if (outs_index !== exp_idx) begin n_fail++; $display("FAIL rr_index cyc=%0d got=%0d exp=%0d", c, outs_index, exp_idx); end
      end
      n_tests++; if (outs !== EXP_CONST) begin n_fail++; $display("FAIL rr_outs cyc=%0d got=%h exp=%h", c, outs, EXP_CONST); end
      tick();
    end
    n_tests++; if (outs_index !== 2'd3) begin n_fail++; $display("FAIL rr_last_index got=%0d exp=3", outs_index); end
    n_tests++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_ptr got=%0d exp=0", dbg_ptr); end
    // A drain with no new request empties the slot. The index and pointer hold.
    ctrl_valid = 4'b0000;
    tick();
    n_tests++; if (outs_valid !== 1'b0) begin n_fail++; $display("FAIL drain_outs_valid got=%b exp=0", outs_valid); end
    n_tests++; if (outs_index !== 2'd3) begin n_fail++; $display("FAIL drain_index got=%0d exp=3", outs_index); end
    n_tests++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL drain_ptr got=%0d exp=0", dbg_ptr); end
  endtask

  task automatic test_backpressure();
    // Load index 2 into the slot. The pointer moves to 3.
    ctrl_valid = 4'b0100; outs_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_fill_grant got=%b exp=0100", ctrl_ready); end
    tick();
    ctrl_valid = 4'b1010; outs_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++; if (ctrl_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, ctrl_ready); end
      n_tests++; if (outs_index !== 2'd2) begin n_fail++; $display("FAIL bp_index cyc=%0d got=%0d exp=2", c, outs_index); end
      n_tests++; if (outs_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", c, outs_valid); end
      n_tests++; if (dbg_ptr !== 2'd3) begin n_fail++; $display("FAIL bp_ptr cyc=%0d got=%0d exp=3", c, dbg_ptr); end
      tick();
    end
    outs_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_resume_grant got=%b exp=1000", ctrl_ready); end
    tick();
    n_tests++; if (outs_index !== 2'd3) begin n_fail++; $display("FAIL bp_resume_index got=%0d exp=3", outs_index); end
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_next_grant got=%b exp=0010", ctrl_ready); end
    tick();
    n_tests++; if (outs_index !== 2'd1) begin n_fail++; $display("FAIL bp_next_index got=%0d exp=1", outs_index); end
    n_tests++; if (dbg_ptr !== 2'd2) begin n_fail++; $display("FAIL bp_next_ptr got=%0d exp=2", dbg_ptr); end
  endtask

  task automatic test_drain_refill();
    // The slot holds index 1 and the pointer is 2. Only requester 2 asks.
    ctrl_valid = 4'b0100; outs_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b0100) begin n_fail++; $display("FAIL dr_grant got=%b exp=0100", ctrl_ready); end
    tick();
    n_tests++; if (outs_valid !== 1'b1) begin n_fail++; $display("FAIL dr_valid got=%b exp=1", outs_valid); end
    n_tests++; if (outs_index !== 2'd2) begin n_fail++; $display("FAIL dr_index got=%0d exp=2", outs_index); end
    // A lone requester is granted again even though the pointer has passed it.
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", ctrl_ready); end
    tick();
    n_tests++; if (dbg_ptr !== 2'd3) begin n_fail++; $display("FAIL single_ptr got=%0d exp=3", dbg_ptr); end
    ctrl_valid = 4'b0000;
    tick();
    n_tests++; if (outs_valid !== 1'b0) begin n_fail++; $display("FAIL dr_drain_valid got=%b exp=0", outs_valid); end
    n_tests++; if (outs_index !== 2'd2) begin n_fail++; $display("FAIL dr_drain_index got=%0d exp=2", outs_index); end
  endtask

  task automatic test_async_reset();
    ctrl_valid = 4'b0010; outs_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b0010) begin n_fail++; $display("FAIL ar_fill_grant got=%b exp=0010", ctrl_ready); end
    tick();
    ctrl_valid = 4'b1111;
    n_tests++; if (outs_valid !== 1'b1) begin n_fail++; $display("FAIL ar_pre_valid got=%b exp=1", outs_valid); end
    n_tests++; if (dbg_ptr !== 2'd2) begin n_fail++; $display("FAIL ar_pre_ptr got=%0d exp=2", dbg_ptr); end
    // Reset asserted between clock edges.
    #2 rst = 1'b1;
    #1;
    n_tests++; if (outs_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_now got=%b exp=0", outs_valid); end
    n_tests++; if (dbg_ptr !== 2'd0) begin n_fail++; $display("FAIL ar_ptr_now got=%0d exp=0", dbg_ptr); end
    n_tests++; if (ctrl_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_ready_in_reset got=%b exp=0000", ctrl_ready); end
    n_tests++; if (outs !== EXP_CONST) begin n_fail++; $display("FAIL ar_outs got=%h exp=%h", outs, EXP_CONST); end
    @(negedge clk);
    #2 rst = 1'b0; ctrl_valid = 4'b0000;
    tick();
    ctrl_valid = 4'b1111; outs_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (ctrl_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first_grant got=%b exp=0001", ctrl_ready); end
    tick();
    n_tests++; if (outs_index !== 2'd0) begin n_fail++; $display("FAIL ar_first_index got=%0d exp=0", outs_index); end
    n_tests++; if (dbg_ptr !== 2'd1) begin n_fail++; $display("FAIL ar_first_ptr got=%0d exp=1", dbg_ptr); end
    ctrl_valid = 4'b0000;
  endtask

  task automatic test_wrap_skip();
    logic [2:0] exp_rdy;
    // Move the 3-requester pointer to 2 by granting requester 1.
    ctrl_valid3 = 3'b010; outs_ready3 = 1'b1;
    tick();
    n_tests++; if (dbg_ptr3 !== 2'd2) begin n_fail++; $display("FAIL wrap_setup_ptr got=%0d exp=2", dbg_ptr3); end
    ctrl_valid3 = 3'b001;
    @(negedge clk);
    n_tests++; if (ctrl_ready3 !== 3'b001) begin n_fail++; $display("FAIL wrap_grant got=%b exp=001", ctrl_ready3); end
    tick();
    n_tests++; if (outs_index3 !== 2'd0) begin n_fail++; $display("FAIL wrap_index got=%0d exp=0", outs_index3); end
    n_tests++; if (dbg_ptr3 !== 2'd1) begin n_fail++; $display("FAIL wrap_ptr got=%0d exp=1", dbg_ptr3); end
    // Starting at pointer 1 with all three requesting, the grants are 1,2,0,1.
    ctrl_valid3 = 3'b111;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp_rdy = 3'b001 << ((c + 1) % 3);
      n_tests++; if (ctrl_ready3 !== exp_rdy) begin n_fail++; $display("FAIL wrap_rr_grant cyc=%0d got=%b exp=%b", c, ctrl_ready3, exp_rdy); end
      n_tests++; if (outs_index3 === 2'd3) begin n_fail++; $display("FAIL wrap_index_range cyc=%0d got=3 exp<3", c); end
      tick();
    end
    n_tests++; if (outs_index3 !== 2'd1) begin n_fail++; $display("FAIL wrap_rr_last got=%0d exp=1", outs_index3); end
    n_tests++; if (dbg_ptr3 !== 2'd2) begin n_fail++; $display("FAIL wrap_rr_ptr got=%0d exp=2", dbg_ptr3); end
    n_tests++; if (outs3 !== EXP_CONST) begin n_fail++; $display("FAIL wrap_outs got=%h exp=%h", outs3, EXP_CONST); end
    ctrl_valid3 = 3'b000;
  endtask

  // ---------------------------------------------------------------- sequence + report
  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_drain_refill();
    test_async_reset();
    test_wrap_skip();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
